lsu_align: RTL and testbench
============================

LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 SHALL provide: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL provide: req_valid  input  1  core load/store request present.
REQ-004 SHALL provide: req_ready  output  1  request accepted when req_valid && req_ready.
REQ-005 SHALL provide: req_we  input  1  1 = store, 0 = load.
REQ-006 SHALL provide: req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 SHALL provide: req_unsigned  input  1  load zero-extend when 1, sign-extend when 0.
REQ-008 SHALL provide: req_addr  input  32  byte address, any alignment.
REQ-009 SHALL provide: req_wdata  input  32  store data, right-justified.
REQ-010 SHALL provide: rsp_valid  output  1  one-cycle completion pulse, loads and stores.
REQ-011 SHALL provide: rsp_rdata  output  32  extended load data; 0 for stores.
REQ-012 SHALL provide: mem_we  output  1  dmem write strobe.
REQ-013 SHALL provide: mem_amp  output  4  dmem byte-lane mask, bit i = byte i of word.
REQ-014 SHALL provide: mem_addr  output  32  word-aligned dmem address (bits[1:0]=00).
REQ-015 SHALL provide: mem_wdata  output  32  lane-aligned store data.
REQ-016 SHALL provide: mem_rdata  input  32  dmem read data, combinational from mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE, BEAT0, BEAT1, RESP; req_ready=1 only in IDLE.
REQ-018 SHALL latch we/size/unsigned/addr/wdata on acceptance and go IDLE->BEAT0; inputs otherwise ignored.
REQ-019 SHALL define off=addr[1:0], nbytes=1/2/4 per size, split = (off+nbytes>4): word with off!=0, half with off=3; byte never splits.
REQ-020 SHALL form 8-bit mask = ((1<<nbytes)-1)<<off and 64-bit data = wdata<<(8*off); beat0 uses mask[3:0]/data[31:0], beat1 uses mask[7:4]/data[63:32].
REQ-021 BEAT0: mem_addr={addr[31:2],00}; next state BEAT1 if split else RESP.
REQ-022 BEAT1: mem_addr={addr[31:2],00}+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); next state RESP.
REQ-023 mem_amp SHALL equal the beat mask for both loads and stores in BEAT0/BEAT1, and 0 in IDLE/RESP.
REQ-024 mem_we SHALL be 1 only in BEAT0/BEAT1 of a store; mem_wdata don't-care when mem_we=0.
REQ-025 Loads SHALL capture mem_rdata into low (BEAT0) / high (BEAT1) halves of a 64-bit register at the end of each beat.
REQ-026 RESP: rsp_valid=1 for exactly one cycle, rsp_rdata = (captured64>>(8*off)) truncated to nbytes, sign/zero-extended per req_unsigned; next state IDLE.
REQ-027 Latency from accept cycle T: rsp_valid in T+2 unaligned-free, T+3 when split; next accept earliest T+3 / T+4.
REQ-028 No back-pressure on rsp; consumer SHALL sample rsp_valid every cycle.
REQ-029 Unused upper captured half SHALL be treated as 0 for non-split loads.

Reset
REQ-030 On reset=0, SHALL immediately (asynchronously) force state IDLE, req_ready=1, rsp_valid=0, mem_we=0, mem_amp=0, mem_addr=0, mem_wdata=0, rsp_rdata=0, clear latched request and capture register.
REQ-031 Reset mid-operation SHALL abandon the access: no further beat, no rsp_valid; a BEAT0-complete split store leaves beat0 bytes written, beat1 not.
REQ-032 After reset deasserts, first request SHALL be accepted on the first rising edge with req_valid=1.

Verification
REQ-033 Aligned word store addr 0x10, wdata 0xDEADBEEF -> one beat: mem_addr 0x10, amp 1111, we=1; rsp_valid at T+2, rsp_rdata 0.
REQ-034 Byte load addr 0x13, mem word 0x80FFFFFF, unsigned=0 -> amp 1000, rsp_rdata 0xFFFFFF80; unsigned=1 -> 0x00000080.
REQ-035 Split word store addr 0x22, wdata 0x11223344 -> beat0 addr 0x20 amp 1100 wdata[31:16]=0x3344; beat1 addr 0x24 amp 0011 wdata[15:0]=0x1122; rsp_valid at T+3.
REQ-036 Split half load addr 0x7, words [0x4]=0xAB000000, [0x8]=0x000000CD, signed -> rsp_rdata 0xFFFFCDAB.
REQ-037 Wrap: word load addr 0xFFFFFFFE -> beat0 addr 0xFFFFFFFC amp 1100, beat1 addr 0x00000000 amp 0011.
REQ-038 Reset asserted during BEAT0 of split store -> mem_we/mem_amp drop to 0 same cycle, no BEAT1 write, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Load/store alignment unit between the core and a word-wide data memory.
// Takes one byte/half/word request at any byte alignment, issues one or two
// word-aligned memory beats with a byte-lane mask, and returns a single
// response pulse carrying the sign/zero-extended load data (0 for stores).
//
// Ports
//   clk           single clock, all state on rising edge
//   reset         asynchronous active-low reset
//   req_valid     core request present
//   req_ready     request accepted when req_valid && req_ready (IDLE only)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10/11 word
//   req_unsigned  load zero-extend when 1, sign-extend when 0
//   req_addr      byte address, any alignment
//   req_wdata     store data, right-justified
//   rsp_valid     one-cycle completion pulse for loads and stores
//   rsp_rdata     extended load data, 0 for stores
//   mem_we        data memory write strobe
//   mem_amp       data memory byte-lane mask, bit i = byte i of the word
//   mem_addr      word-aligned data memory address
//   mem_wdata     lane-aligned store data
//   mem_rdata     data memory read data, combinational from mem_addr
//
// State table
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   BEAT0 | first memory beat at the word holding the start address
//   BEAT1 | second beat at the next word, only for accesses that cross it
//   RESP  | rsp_valid pulse with the extended load data
// ---------------------------------------------------------------------------
module lsu_align (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        mem_we,
   output logic [3:0]  mem_amp,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BEAT0 = 2'b01,
      BEAT1 = 2'b10,
      RESP  = 2'b11
   } state_t;

   state_t      state;

   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [63:0] cap_q;

   logic [3:0]  in_amp;
   logic [31:0] in_wdata;
   logic [31:0] in_base;
   logic [3:0]  q_amp_hi;
   logic [31:0] q_wdata_hi;
   logic        q_split;
   logic [31:0] q_base_next;
   logic [31:0] rd_beat0;
   logic [31:0] rd_beat1;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Byte-lane mask over the two-word window starting at the first word.
   function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                            input logic [1:0] off);
      logic [7:0] m;
      m = (8'd1 << size_bytes(size)) - 8'd1;
      return m << off;
   endfunction

   // Store data shifted into its byte lanes across the two-word window.
   function automatic logic [63:0] lane_data(input logic [31:0] wdata,
                                             input logic [1:0]  off);
      return {32'h0, wdata} << {off, 3'b000};
   endfunction

   function automatic logic crosses_word(input logic [1:0] size,
                                         input logic [1:0] off);
      return ({2'b00, off} + {1'b0, size_bytes(size)}) > 4'd4;
   endfunction

   // Pull the addressed bytes out of the captured window and extend them.
   function automatic logic [31:0] extract_load(input logic [63:0] cap,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        uns);
      logic [31:0] sh;
      sh = 32'(cap >> {off, 3'b000});
      case (size)
         2'b00:   return uns ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
         2'b01:   return uns ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   // Beat-0 outputs are loaded on the accept edge, so they come straight from
   // the request inputs; later beats use the latched copy.
   assign in_amp      = 4'(lane_mask(req_size, req_addr[1:0]));
   assign in_wdata    = 32'(lane_data(req_wdata, req_addr[1:0]));
   assign in_base     = {req_addr[31:2], 2'b00};

   assign q_amp_hi    = 4'(lane_mask(size_q, addr_q[1:0]) >> 4);
   assign q_wdata_hi  = 32'(lane_data(wdata_q, addr_q[1:0]) >> 32);
   assign q_split     = crosses_word(size_q, addr_q[1:0]);
   // 32-bit add wraps 0xFFFFFFFC to 0x00000000 on its own.
   assign q_base_next = {addr_q[31:2], 2'b00} + 32'd4;

   // The response is registered on the edge that closes the last beat, so the
   // window is built from the capture register plus the live read data. The
   // upper half of cap_q is cleared on accept, which zero-fills it for
   // single-beat loads.
   assign rd_beat0    = extract_load({cap_q[63:32], mem_rdata}, addr_q[1:0],
                                     size_q, uns_q);
   assign rd_beat1    = extract_load({mem_rdata, cap_q[31:0]}, addr_q[1:0],
                                     size_q, uns_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         mem_we    <= 1'b0;
         mem_amp   <= 4'h0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         we_q      <= 1'b0;
         size_q    <= 2'b00;
         uns_q     <= 1'b0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         cap_q     <= 64'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  we_q      <= req_we;
                  size_q    <= req_size;
                  uns_q     <= req_unsigned;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  cap_q     <= 64'h0;
                  req_ready <= 1'b0;
                  mem_addr  <= in_base;
                  mem_amp   <= in_amp;
                  mem_we    <= req_we;
                  mem_wdata <= in_wdata;
                  state     <= BEAT0;
               end
            end

            BEAT0: begin
               cap_q[31:0] <= mem_rdata;
               if (q_split) begin
                  mem_addr  <= q_base_next;
                  mem_amp   <= q_amp_hi;
                  mem_wdata <= q_wdata_hi;
                  state     <= BEAT1;
               end else begin
                  mem_amp   <= 4'h0;
                  mem_we    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= we_q ? 32'h0 : rd_beat0;
                  state     <= RESP;
               end
            end

            BEAT1: begin
               cap_q[63:32] <= mem_rdata;
               mem_amp      <= 4'h0;
               mem_we       <= 1'b0;
               rsp_valid    <= 1'b1;
               rsp_rdata    <= we_q ? 32'h0 : rd_beat1;
               state        <= RESP;
            end

            RESP: begin
               rsp_valid <= 1'b0;
               rsp_rdata <= 32'h0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end

            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               mem_amp   <= 4'h0;
               mem_we    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_align.sv
module tb_lsu_align;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        mem_we;
   logic [3:0]  mem_amp;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   lsu_align dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .mem_we       (mem_we),
      .mem_amp      (mem_amp),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests;
   int n_fail;

   // Word memory seen by the DUT (1 KiB window, address bits [9:2]) and a
   // byte-level shadow maintained only from the bench's own stimulus.
   logic [31:0] dmem [0:255];
   logic [7:0]  shadow [0:1023];
   logic        mem_clr;
   logic        pre_we;
   logic [7:0]  pre_idx;
   logic [31:0] pre_val;

   assign mem_rdata = dmem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
      end else if (pre_we) begin
         dmem[pre_idx] <= pre_val;
      end else if (mem_we) begin
         for (int j = 0; j < 4; j++)
            if (mem_amp[j]) dmem[mem_addr[9:2]][8*j +: 8] <= mem_wdata[8*j +: 8];
      end
   end

   logic [31:0] exp_q [$];
   logic [31:0] addr_log [1:8];
   logic [3:0]  amp_log  [1:8];
   logic        we_log   [1:8];
   logic [31:0] wd_log   [1:8];
   int          last_lat;
   logic [31:0] last_rdata;

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] addr,
                                              input logic [1:0] size,
                                              input logic uns);
      int nb;
      logic [31:0] v;
      logic [31:0] a;
      nb = nbytes(size);
      v = 32'h0;
      for (int i = 0; i < nb; i++) begin
         a = addr + 32'(i);
         v[8*i +: 8] = shadow[a[9:0]];
      end
      if (!uns && nb < 4 && v[8*nb-1])
         for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [3:0] exp_amp(input logic [31:0] addr,
                                          input logic [1:0] size, input int beat);
      logic [3:0] m;
      int lane;
      m = 4'h0;
      for (int i = 0; i < nbytes(size); i++) begin
         lane = int'(addr[1:0]) + i;
         if (beat == 0 && lane < 4) m[lane] = 1'b1;
         if (beat == 1 && lane >= 4) m[lane-4] = 1'b1;
      end
      return m;
   endfunction

   task automatic model_store(input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] wdata);
      logic [31:0] a;
      for (int i = 0; i < nbytes(size); i++) begin
         a = addr + 32'(i);
         shadow[a[9:0]] = wdata[8*i +: 8];
      end
   endtask

   task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
      @(negedge clk);
      pre_we  = 1'b1;
      pre_idx = addr[9:2];
      pre_val = val;
      for (int i = 0; i < 4; i++) shadow[{addr[9:2], 2'(i)}] = val[8*i +: 8];
      @(posedge clk);
      #1 pre_we = 1'b0;
   endtask

   // Issue one request, push its expected response, follow the beats and
   // pop/compare when the response pulse arrives.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
      int          nb;
      int          exp_lat;
      int          idx;
      logic        bad;
      logic [31:0] base;
      logic [31:0] exp_rd;
      nb      = nbytes(size);
      exp_lat = (int'(addr[1:0]) + nb > 4) ? 3 : 2;
      base    = {addr[31:2], 2'b00};
      @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_before_req got ready=%b rsp_valid=%b expected 1/0", req_ready, rsp_valid);
      end
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      if (we) begin
         model_store(addr, size, wdata);
         exp_q.push_back(32'h0);
      end else begin
         exp_q.push_back(model_load(addr, size, uns));
      end
      @(posedge clk);
      // Keep junk requests on the bus while busy; they must be ignored.
      #1;
      req_we    = 1'($urandom);
      req_size  = 2'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      last_lat  = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         addr_log[k] = mem_addr;
         amp_log[k]  = mem_amp;
         we_log[k]   = mem_we;
         wd_log[k]   = mem_wdata;
         if (rsp_valid === 1'b1) begin
            last_lat = k;
            break;
         end
      end
      n_tests++;
      if (last_lat == 0) begin
         n_fail++;
         $display("FAIL rsp_timeout addr=%h got no rsp_valid expected one within 8 cycles", addr);
         void'(exp_q.pop_front());
         req_valid = 1'b0;
         return;
      end
      exp_rd     = exp_q.pop_front();
      last_rdata = rsp_rdata;
      if (rsp_rdata !== exp_rd) begin
         n_fail++;
         $display("FAIL rsp_rdata addr=%h size=%0d we=%b got %h expected %h", addr, size, we, rsp_rdata, exp_rd);
      end
      n_tests++;
      if (req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_in_resp got %b expected 0", req_ready);
      end
      req_valid = 1'b0;
      n_tests++;
      if (last_lat != exp_lat) begin
         n_fail++;
         $display("FAIL latency addr=%h size=%0d got %0d expected %0d", addr, size, last_lat, exp_lat);
      end
      n_tests++;
      if ({addr_log[1], amp_log[1], we_log[1]} !== {base, exp_amp(addr, size, 0), we}) begin
         n_fail++;
         $display("FAIL beat0 got addr=%h amp=%b we=%b expected addr=%h amp=%b we=%b",
                  addr_log[1], amp_log[1], we_log[1], base, exp_amp(addr, size, 0), we);
      end
      if (exp_lat == 3 && last_lat == 3) begin
         n_tests++;
         if ({addr_log[2], amp_log[2], we_log[2]} !== {base + 32'd4, exp_amp(addr, size, 1), we}) begin
            n_fail++;
            $display("FAIL beat1 got addr=%h amp=%b we=%b expected addr=%h amp=%b we=%b",
                     addr_log[2], amp_log[2], we_log[2], base + 32'd4, exp_amp(addr, size, 1), we);
         end
      end
      if (we && last_lat == exp_lat) begin
         bad = 1'b0;
         for (int b = 0; b < exp_lat - 1; b++)
            for (int j = 0; j < 4; j++) begin
               idx = 4*b + j - int'(addr[1:0]);
               if (idx >= 0 && idx < nb && wd_log[b+1][8*j +: 8] !== wdata[8*idx +: 8]) bad = 1'b1;
            end
         n_tests++;
         if (bad) begin
            n_fail++;
            $display("FAIL store_lanes addr=%h got beat0=%h beat1=%h expected bytes of %h", addr, wd_log[1], wd_log[2], wdata);
         end
      end
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      mem_clr = 1'b1;
      reset   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({req_ready, rsp_valid, mem_we, mem_amp} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
         n_fail++;
         $display("FAIL reset_ctrl got ready=%b rsp=%b we=%b amp=%b expected 1/0/0/0000", req_ready, rsp_valid, mem_we, mem_amp);
      end
      check32("reset_mem_addr", mem_addr, 32'h0);
      check32("reset_mem_wdata", mem_wdata, 32'h0);
      check32("reset_rsp_rdata", rsp_rdata, 32'h0);
      mem_clr = 1'b0;
      reset   = 1'b1;
   endtask

   task automatic test_aligned_store();
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      check32("st_al_addr", addr_log[1], 32'h10);
      check32("st_al_amp", {28'h0, amp_log[1]}, 32'hF);
      check32("st_al_lat", 32'(last_lat), 32'd2);
      check32("st_al_mem", dmem[4], 32'hDEADBEEF);
   endtask

   task automatic test_byte_load();
      set_word(32'h10, 32'h80FFFFFF);
      do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      check32("ldb_amp", {28'h0, amp_log[1]}, 32'h8);
      check32("ldb_signed", last_rdata, 32'hFFFFFF80);
      do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
      check32("ldb_unsigned", last_rdata, 32'h00000080);
   endtask

   task automatic test_split_store();
      set_word(32'h20, 32'h0);
      set_word(32'h24, 32'h0);
      do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h11223344);
      check32("sst_b0", {addr_log[1][31:4], amp_log[1]}, {28'h2, 4'b1100});
      check32("sst_b0_data", {16'h0, wd_log[1][31:16]}, 32'h3344);
      check32("sst_b1", addr_log[2], 32'h24);
      check32("sst_b1_amp", {28'h0, amp_log[2]}, 32'h3);
      check32("sst_b1_data", {16'h0, wd_log[2][15:0]}, 32'h1122);
      check32("sst_lat", 32'(last_lat), 32'd3);
      check32("sst_mem0", dmem[8], 32'h33440000);
      check32("sst_mem1", dmem[9], 32'h00001122);
   endtask

   task automatic test_split_half_load();
      set_word(32'h4, 32'hAB000000);
      set_word(32'h8, 32'h000000CD);
      do_req(1'b0, 2'b01, 1'b0, 32'h7, 32'h0);
      check32("ldh_split", last_rdata, 32'hFFFFCDAB);
      check32("ldh_lat", 32'(last_lat), 32'd3);
   endtask

   task automatic test_wrap();
      set_word(32'hFFFFFFFC, 32'h12340000);
      set_word(32'h0, 32'h00005678);
      do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
      check32("wrap_b0_addr", addr_log[1], 32'hFFFFFFFC);
      check32("wrap_b0_amp", {28'h0, amp_log[1]}, 32'hC);
      check32("wrap_b1_addr", addr_log[2], 32'h0);
      check32("wrap_b1_amp", {28'h0, amp_log[2]}, 32'h3);
      check32("wrap_data", last_rdata, 32'h56781234);
   endtask

   // Split store at 0x42 interrupted by reset during the given beat (1 or 2).
   task automatic reset_during_store(input int beat);
      logic seen;
      set_word(32'h40, 32'h0);
      set_word(32'h44, 32'h0);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 32'h42;
      req_wdata = 32'hAABBCCDD;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (beat) @(negedge clk);
      n_tests++;
      if (mem_we !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre_we beat=%0d got %b expected 1", beat, mem_we);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if ({mem_we, mem_amp, req_ready, rsp_valid} !== {1'b0, 4'h0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_async beat=%0d got we=%b amp=%b ready=%b rsp=%b expected 0/0000/1/0",
                  beat, mem_we, mem_amp, req_ready, rsp_valid);
      end
      check32("rst_async_addr", mem_addr, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen  = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL rst_no_rsp beat=%0d got rsp_valid=1 expected 0", beat);
      end
      if (beat == 2) begin
         shadow[10'h42] = 8'hDD;
         shadow[10'h43] = 8'hCC;
         check32("rst_b1_word0", dmem[16], 32'hCCDD0000);
      end else begin
         check32("rst_b0_word0", dmem[16], 32'h0);
      end
      check32("rst_word1", dmem[17], 32'h0);
   endtask

   task automatic test_reset_mid();
      reset_during_store(1);
      reset_during_store(2);
      do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
      check32("post_rst_load", last_rdata, 32'hCCDD0000);
   endtask

   task automatic test_back_to_back();
      do_req(1'b1, 2'b01, 1'b0, 32'h81, 32'h0000BEEF);
      do_req(1'b0, 2'b01, 1'b1, 32'h81, 32'h0);
      do_req(1'b1, 2'b00, 1'b0, 32'h83, 32'h000000F0);
      do_req(1'b0, 2'b11, 1'b0, 32'h81, 32'h0);
      do_req(1'b1, 2'b10, 1'b0, 32'h87, 32'hCAFEF00D);
      do_req(1'b0, 2'b01, 1'b0, 32'h87, 32'h0);
   endtask

   task automatic test_random();
      int bad;
      for (int n = 0; n < 40; n++)
         do_req(1'($urandom), 2'($urandom), 1'($urandom),
                32'h100 + 32'($urandom_range(0, 127)), $urandom);
      bad = 0;
      for (int i = 0; i < 1024; i++)
         if (dmem[i/4][8*(i%4) +: 8] !== shadow[i]) bad++;
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL mem_sweep got %0d differing bytes expected 0", bad);
      end
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      reset        = 1'b0;
      mem_clr      = 1'b1;
      pre_we       = 1'b0;
      pre_idx      = 8'h0;
      pre_val      = 32'h0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      for (int i = 0; i < 1024; i++) shadow[i] = 8'h0;
      test_reset();
      test_aligned_store();
      test_byte_load();
      test_split_store();
      test_split_half_load();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_left got %0d entries expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish expected completion");
      $fatal(1, "watchdog");
   end

endmodule
